// File: rtl/icache_pkg.sv
// Shared constants and types for the instruction cache.
// Contents: line width, default geometry, the FSM state type, and the
// index/tag/line types for the default configuration.
package icache_pkg;

    localparam int ICLLEN    = 128;
    localparam int IC_ADDR_W = 32;
    localparam int IC_NLINES = 16;
    localparam int IC_OFF_W  = 4;
    localparam int IC_IDX_W  = $clog2(IC_NLINES);
    localparam int IC_TAG_W  = IC_ADDR_W - IC_OFF_W - IC_IDX_W;

    typedef enum logic {IC_LOOKUP, IC_MISS} icache_state_t;

    typedef logic [IC_IDX_W-1:0] ic_idx_t;
    typedef logic [IC_TAG_W-1:0] ic_tag_t;
    typedef logic [ICLLEN-1:0]   ic_line_t;

endpackage

// File: rtl/instruction_bus.sv
// Line-refill bus between the instruction cache and main memory.
// The consumer raises ldp with ldAddr and holds both until the provider
// answers with a one-cycle ldr carrying the full line on ldData.
interface instruction_bus #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);
    logic              ldp;
    logic [ADDR_W-1:0] ldAddr;
    logic              ldr;
    logic [LINE_W-1:0] ldData;

    modport consumer (output ldp, output ldAddr, input ldr, input ldData);
    modport provider (input ldp, input ldAddr, output ldr, output ldData);
endinterface

// File: rtl/icache_store.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Ports:
//   clk, rst            clock, synchronous active-high reset (clears valid only)
//   we_i/widx_i/...     single write port: tag, line and valid bit for one index
//   inval_i             clear every valid bit on the next edge
//   ridx_i              combinational read index
//   rvalid_o/rtag_o/rdata_o  contents of the read index
module icache_store #(
    parameter int NLINES = 16,
    parameter int TAG_W  = 24,
    parameter int LINE_W = 128,
    localparam int IDX_W = $clog2(NLINES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  widx_i,
    input  logic [TAG_W-1:0]  wtag_i,
    input  logic [LINE_W-1:0] wdata_i,
    input  logic              wvalid_i,
    input  logic              inval_i,
    input  logic [IDX_W-1:0]  ridx_i,
    output logic              rvalid_o,
    output logic [TAG_W-1:0]  rtag_o,
    output logic [LINE_W-1:0] rdata_o
);

    logic [NLINES-1:0] valid_q;
    logic [TAG_W-1:0]  tag_q  [NLINES];
    logic [LINE_W-1:0] data_q [NLINES];

    // Bulk invalidate first, then the write port: a fill in the same cycle
    // as an invalidate carries its own (already cleared) valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            if (inval_i) valid_q <= '0;
            if (we_i)    valid_q[widx_i] <= wvalid_i;
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[widx_i]  <= wtag_i;
            data_q[widx_i] <= wdata_i;
        end
    end

    assign rvalid_o = valid_q[ridx_i];
    assign rtag_o   = tag_q[ridx_i];
    assign rdata_o  = data_q[ridx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache.
// Hits return the instruction combinationally; a miss stalls fetch and
// refills one line over the instruction bus, then replays the lookup.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   fetch_req_i     fetch request for pc_i
//   pc_i            fetch address (bits [1:0] ignored)
//   flush_i         invalidate all lines
//   instr_o         selected instruction word
//   instr_valid_o   hit this cycle
//   stall_o         fetch must hold and retry
//   bus             refill bus, consumer side
module icache
    import icache_pkg::*;
#(
    parameter int ADDR_W = IC_ADDR_W,
    parameter int NLINES = IC_NLINES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              flush_i,
    output logic [31:0]       instr_o,
    output logic              instr_valid_o,
    output logic              stall_o,
    instruction_bus.consumer  bus
);

    localparam int IDX_W = $clog2(NLINES);
    localparam int TAG_W = ADDR_W - IC_OFF_W - IDX_W;

    icache_state_t     state_q, state_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;

    logic [IDX_W-1:0]  pc_idx, miss_idx;
    logic [TAG_W-1:0]  pc_tag, miss_tag, rtag;
    logic [1:0]        pc_word;
    logic [ICLLEN-1:0] rdata;
    logic              rvalid, hit, fill;
    logic              unused_pc;

    assign pc_tag    = pc_i[ADDR_W-1:IC_OFF_W+IDX_W];
    assign pc_idx    = pc_i[IC_OFF_W+IDX_W-1:IC_OFF_W];
    assign pc_word   = pc_i[3:2];
    assign miss_tag  = miss_addr_q[ADDR_W-1:IC_OFF_W+IDX_W];
    assign miss_idx  = miss_addr_q[IC_OFF_W+IDX_W-1:IC_OFF_W];
    assign unused_pc = ^{pc_i[1:0], miss_addr_q[IC_OFF_W-1:0]};

    icache_store #(
        .NLINES (NLINES),
        .TAG_W  (TAG_W),
        .LINE_W (ICLLEN)
    ) u_store (
        .clk      (clk),
        .rst      (rst),
        .we_i     (fill),
        .widx_i   (miss_idx),
        .wtag_i   (miss_tag),
        .wdata_i  (bus.ldData),
        .wvalid_i (~drop_q & ~flush_i),
        .inval_i  (flush_i),
        .ridx_i   (pc_idx),
        .rvalid_o (rvalid),
        .rtag_o   (rtag),
        .rdata_o  (rdata)
    );

    assign hit     = rvalid && (rtag == pc_tag);
    assign instr_o = rdata[{pc_word, 5'b0} +: 32];

    assign bus.ldp    = (state_q == IC_MISS);
    assign bus.ldAddr = miss_addr_q;

    always_comb begin
        state_d       = state_q;
        drop_d        = drop_q;
        miss_addr_d   = miss_addr_q;
        instr_valid_o = 1'b0;
        stall_o       = 1'b0;
        fill          = 1'b0;
        unique case (state_q)
            IC_LOOKUP: begin
                if (fetch_req_i) begin
                    if (hit) begin
                        instr_valid_o = 1'b1;
                    end else begin
                        stall_o     = 1'b1;
                        miss_addr_d = {pc_i[ADDR_W-1:IC_OFF_W], {IC_OFF_W{1'b0}}};
                        state_d     = IC_MISS;
                    end
                end
            end
            IC_MISS: begin
                stall_o = 1'b1;
                if (bus.ldr) begin
                    fill    = ~rst;
                    drop_d  = 1'b0;
                    state_d = IC_LOOKUP;
                end else if (flush_i) begin
                    // Line in flight predates the flush: write it but keep it invalid.
                    drop_d = 1'b1;
                end
            end
            default: state_d = IC_LOOKUP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IC_LOOKUP;
            drop_q      <= 1'b0;
            miss_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            drop_q      <= drop_d;
            miss_addr_q <= miss_addr_d;
        end
    end

endmodule

// File: tb/tb_icache.sv
module tb_icache;
    localparam logic [127:0] LINE = 128'h00408093_00308093_00208093_00108093;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_req = 1'b0;
    logic [31:0] pc = 32'h0;
    logic        flush = 1'b0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;

    logic         mem_ldr = 1'b0;
    logic [127:0] mem_data = '0;
    logic         ldp_prev = 1'b0;
    int           req_cnt = 0;

    int n_assert = 0;
    int n_fail = 0;

    instruction_bus #(.ADDR_W(32), .LINE_W(128)) bus_if ();

    assign bus_if.ldr    = mem_ldr;
    assign bus_if.ldData = mem_data;

    icache dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_req_i   (fetch_req),
        .pc_i          (pc),
        .flush_i       (flush),
        .instr_o       (instr),
        .instr_valid_o (instr_valid),
        .stall_o       (stall),
        .bus           (bus_if)
    );

    always #5 clk = ~clk;

    // Memory model: answers a pending ldp one cycle after seeing it, line = LINE ^ {4{addr}}.
    always @(posedge clk) begin
        if (bus_if.ldp && !mem_ldr) begin
            mem_ldr  <= 1'b1;
            mem_data <= LINE ^ {4{bus_if.ldAddr}};
        end else begin
            mem_ldr  <= 1'b0;
        end
        ldp_prev <= bus_if.ldp;
        if (bus_if.ldp && !ldp_prev) req_cnt <= req_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Call at the miss-detect cycle (#1 after negedge); returns at the first non-stalled cycle.
    task automatic run_miss(input string tag, input logic [31:0] exp_addr, input int exp_stalls);
        int          stalls = 0;
        logic        seen = 1'b0;
        logic [31:0] addr = 32'hdead_beef;
        while (stall && stalls < 20) begin
            if (bus_if.ldp && !seen) begin
                seen = 1'b1;
                addr = bus_if.ldAddr;
            end
            stalls++;
            step(); #1;
        end
        chk({tag, "_stalls"}, stalls, exp_stalls);
        chk({tag, "_ldaddr"}, addr, exp_addr);
    endtask

    task automatic lookup_hit(input string tag, input logic [31:0] a, input logic [31:0] exp);
        step();
        pc = a; fetch_req = 1'b1;
        #1;
        chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
        chk({tag, "_stall"}, {31'b0, stall}, 32'd0);
        chk({tag, "_instr"}, instr, exp);
    endtask

    int base;

    initial begin
        // Reset
        step(); step(); #1;
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_ldp", {31'b0, bus_if.ldp}, 32'd0);
        chk("rst_ldaddr", bus_if.ldAddr, 32'h0);
        step(); rst = 1'b0;

        // 1: cold miss at 0x0
        step(); pc = 32'h0; fetch_req = 1'b1; #1;
        chk("t1_detect_stall", {31'b0, stall}, 32'd1);
        chk("t1_detect_ldp", {31'b0, bus_if.ldp}, 32'd0);
        step(); #1;
        chk("t1_ldp", {31'b0, bus_if.ldp}, 32'd1);
        chk("t1_ldaddr", bus_if.ldAddr, 32'h0);
        chk("t1_stall2", {31'b0, stall}, 32'd1);
        step(); #1;
        chk("t1_stall3", {31'b0, stall}, 32'd1);
        step(); #1;
        chk("t1_hit", {31'b0, instr_valid}, 32'd1);
        chk("t1_instr", instr, 32'h00108093);
        chk("t1_ldp_low", {31'b0, bus_if.ldp}, 32'd0);
        chk("t1_reqs", req_cnt, 32'd1);

        // 2: remaining words of the line hit back to back
        lookup_hit("t2_w1", 32'h4, 32'h00208093);
        lookup_hit("t2_w2", 32'h8, 32'h00308093);
        lookup_hit("t2_w3", 32'hC, 32'h00408093);
        chk("t2_reqs", req_cnt, 32'd1);

        // 3: conflict at idx 0
        step(); pc = 32'h100; #1;
        run_miss("t3_100", 32'h100, 3);
        chk("t3_100_instr", instr, 32'h00108193);
        step(); pc = 32'h0; #1;
        run_miss("t3_0", 32'h0, 3);
        chk("t3_0_instr", instr, 32'h00108093);

        // 4: flush in LOOKUP; same-cycle lookup still hits
        step(); pc = 32'h0; flush = 1'b1; #1;
        chk("t4_flush_cycle_hit", {31'b0, instr_valid}, 32'd1);
        step(); flush = 1'b0; #1;
        chk("t4_post_flush_miss", {31'b0, stall}, 32'd1);
        run_miss("t4_refill", 32'h0, 3);

        // 4b: flush during MISS drops the line; replay misses again
        base = req_cnt;
        step(); pc = 32'h80; #1;
        chk("t4b_detect", {31'b0, stall}, 32'd1);
        step(); flush = 1'b1; #1;
        chk("t4b_ldp", {31'b0, bus_if.ldp}, 32'd1);
        step(); flush = 1'b0; #1;
        step(); #1;
        chk("t4b_replay_miss", {31'b0, stall}, 32'd1);
        chk("t4b_replay_valid", {31'b0, instr_valid}, 32'd0);
        run_miss("t4b_second", 32'h80, 3);
        chk("t4b_instr", instr, 32'h00108013);
        chk("t4b_reqs", req_cnt - base, 32'd2);

        // 5: reset in the MISS cycle
        step(); pc = 32'h20; #1;
        chk("t5_detect", {31'b0, stall}, 32'd1);
        step(); rst = 1'b1; fetch_req = 1'b0; #1;
        chk("t5_ldp_in_miss", {31'b0, bus_if.ldp}, 32'd1);
        step(); rst = 1'b0; #1;
        chk("t5_ldp_after", {31'b0, bus_if.ldp}, 32'd0);
        chk("t5_stall_after", {31'b0, stall}, 32'd0);
        step(); pc = 32'h80; fetch_req = 1'b1; #1;
        chk("t5_80_invalid", {31'b0, stall}, 32'd1);
        run_miss("t5_80", 32'h80, 3);
        step(); pc = 32'h0; #1;
        run_miss("t5_0", 32'h0, 3);

        // 6: pc changes mid-stall; late ldr from step 5 left idx 2 invalid
        step(); pc = 32'h20; #1;
        chk("t6_detect", {31'b0, stall}, 32'd1);
        step(); pc = 32'h40; #1;
        chk("t6_ldaddr20", bus_if.ldAddr, 32'h20);
        step(); #1;
        step(); #1;
        chk("t6_replay_miss", {31'b0, stall}, 32'd1);
        run_miss("t6_40", 32'h40, 3);
        chk("t6_40_instr", instr, 32'h001080d3);
        lookup_hit("t6_20", 32'h20, 32'h001080b3);
        lookup_hit("t6_24", 32'h24, 32'h002080b3);

        step(); fetch_req = 1'b0; #1;
        chk("idle_valid", {31'b0, instr_valid}, 32'd0);
        chk("idle_stall", {31'b0, stall}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
